// File: rtl/uart_tx_serializer.sv
// Purpose : byte-wide UART transmitter; serialises one latched byte as 8N1 (8E1 with UART_TX_PARITY_EN).
// Latency : tx drops to the start bit on the launch edge; done pulses 10 (11 with parity) bit periods later.
// Backpres: no queueing; a tx_start rise while busy is ignored, and en low aborts the frame without done.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   en        transmitter enable; low in any active state aborts the frame
//   tx_start  level-held start request; a frame launches on its rising edge in IDLE
//   data_in   byte to send, latched at launch
//   tx        serial line, idle high (registered)
//   busy      high while a frame is in progress (registered)
//   done      one-cycle pulse at the end of the stop bit (registered)
//
// Build option: define UART_TX_PARITY_EN to add an even-parity bit after data bit 7.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       tx_start,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int TW = $clog2(CLKS_PER_BIT);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;
  logic          bit_end;
  logic          start_q;
  logic [7:0]    shreg_q;
  logic [2:0]    idx_q;
  logic          tx_q;
  logic          busy_q;
  logic          done_q;
`ifdef UART_TX_PARITY_EN
  logic          parity_q;
`endif

  // Bit timer runs 0..CLKS_PER_BIT-1; the last count marks the end of the current bit.
  assign bit_end = (timer_q == TW'(CLKS_PER_BIT - 1));
  assign timer_d = bit_end ? '0 : timer_q + TW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      start_q  <= 1'b0;
      shreg_q  <= '0;
      idx_q    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      // start_q tracks tx_start every cycle so a level held across done cannot relaunch.
      start_q <= tx_start;
      done_q  <= 1'b0;
      if (state_q != IDLE && !en) begin
        // Abort: drop straight back to idle, line high, no completion pulse.
        state_q <= IDLE;
        timer_q <= '0;
        tx_q    <= 1'b1;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (en && tx_start && !start_q) begin
              shreg_q  <= data_in;
`ifdef UART_TX_PARITY_EN
              parity_q <= ^data_in;
`endif
              idx_q    <= '0;
              timer_q  <= '0;
              tx_q     <= 1'b0;
              busy_q   <= 1'b1;
              state_q  <= START;
            end
          end
          START: begin
            timer_q <= timer_d;
            if (bit_end) begin
              tx_q    <= shreg_q[0];
              state_q <= DATA;
            end
          end
          DATA: begin
            timer_q <= timer_d;
            if (bit_end) begin
              shreg_q <= {1'b0, shreg_q[7:1]};
              if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                tx_q    <= parity_q;
                state_q <= PARITY;
`else
                tx_q    <= 1'b1;
                state_q <= STOP;
`endif
              end else begin
                // Next bit is shreg_q[1] because the shift lands on this same edge.
                tx_q  <= shreg_q[1];
                idx_q <= idx_q + 3'd1;
              end
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            timer_q <= timer_d;
            if (bit_end) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end
          end
`endif
          STOP: begin
            timer_q <= timer_d;
            if (bit_end) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
          default: begin
            state_q <= IDLE;
            timer_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

  localparam int C  = 4;
  localparam int C2 = 434;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, tx_start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       tx, busy, done;
  logic       en2 = 1'b0, start2 = 1'b0;
  logic [7:0] din2 = 8'h00;
  logic       tx2, busy2, done2;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [2:0] exp_q[$];   // {tx, busy, done} expected per cycle

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_serializer #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .tx_start(tx_start), .data_in(data_in),
    .tx(tx), .busy(busy), .done(done)
  );

  uart_tx_serializer #(.CLKS_PER_BIT(C2)) dut_b2b (
    .clk(clk), .rst_n(rst_n), .en(en2), .tx_start(start2), .data_in(din2),
    .tx(tx2), .busy(busy2), .done(done2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected per-cycle line activity from the launch edge onward.
  task automatic push_frame(input logic [7:0] b, input int c);
    logic [10:0] bits;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = b[i];
    if (NB == 11) bits[9] = ^b;
    bits[NB-1] = 1'b1;
    for (int t = 0; t < NB*c; t++) exp_q.push_back({bits[t/c], 1'b1, 1'b0});
    exp_q.push_back(3'b101);
    exp_q.push_back(3'b100);
  endtask

  // Raise tx_start with byte b; returns positioned just after the launch edge.
  task automatic launch(input logic [7:0] b);
    data_in  = b;
    tx_start = 1'b1;
    push_frame(b, C);
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    vectors++;
    if ({tx, busy, done} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_held got tx/busy/done=%b want 100", {tx, busy, done});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      vectors++;
      if ({tx, busy, done, tx2, busy2, done2} !== 6'b100100) begin
        miscompares++;
        $display("FAIL reset_idle cyc=%0d got %b want 100100", i, {tx, busy, done, tx2, busy2, done2});
      end
    end
  endtask

  task automatic test_single_a5();
    logic [2:0] e;
    int t;
    en = 1'b1;
    step();
    launch(8'hA5);
    t = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if ({tx, busy, done} !== e) begin
        miscompares++;
        $display("FAIL single_a5 t=%0d got %b want %b", t, {tx, busy, done}, e);
      end
      if (t == 1) data_in = 8'h3C;   // must not disturb the latched byte
      if (e[0]) tx_start = 1'b0;
      t++;
      step();
    end
  endtask

  task automatic test_byte_07();
    logic [2:0] e;
    int t;
    step();
    launch(8'h07);
    t = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if ({tx, busy, done} !== e) begin
        miscompares++;
        $display("FAIL byte_07 t=%0d got %b want %b", t, {tx, busy, done}, e);
      end
`ifdef UART_TX_PARITY_EN
      if (t == 9*C + 1) begin
        vectors++;
        if (tx !== 1'b1) begin
          miscompares++;
          $display("FAIL parity_bit got %b want 1", tx);
        end
      end
`endif
      if (e[0]) tx_start = 1'b0;
      t++;
      step();
    end
  endtask

  task automatic test_held_start();
    logic [2:0] e;
    int dones;
    step();
    launch(8'h5A);
    dones = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if ({tx, busy, done} !== e) begin
        miscompares++;
        $display("FAIL held_frame got %b want %b", {tx, busy, done}, e);
      end
      if (done) dones++;
      step();
    end
    for (int i = 0; i < 200; i++) begin
      vectors++;
      if ({tx, busy, done} !== 3'b100) begin
        miscompares++;
        $display("FAIL held_relaunch i=%0d got %b want 100", i, {tx, busy, done});
      end
      if (done) dones++;
      step();
    end
    vectors++;
    if (dones !== 1) begin
      miscompares++;
      $display("FAIL held_done_count got %0d want 1", dones);
    end
    tx_start = 1'b0;
    step();
  endtask

  task automatic test_abort();
    logic [2:0] e;
    step();
    launch(8'hFF);
    for (int t = 0; t <= 13; t++) begin
      e = exp_q.pop_front();
      vectors++;
      if ({tx, busy, done} !== e) begin
        miscompares++;
        $display("FAIL abort_pre t=%0d got %b want %b", t, {tx, busy, done}, e);
      end
      if (t == 13) en = 1'b0;
      else step();
    end
    exp_q.delete();
    step();
    vectors++;
    if ({tx, busy, done} !== 3'b100) begin
      miscompares++;
      $display("FAIL abort_idle got %b want 100", {tx, busy, done});
    end
    tx_start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      vectors++;
      if ({tx, busy, done} !== 3'b100) begin
        miscompares++;
        $display("FAIL abort_no_done i=%0d got %b want 100", i, {tx, busy, done});
      end
    end
    en = 1'b1;
    step();
    launch(8'hFF);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if ({tx, busy, done} !== e) begin
        miscompares++;
        $display("FAIL abort_resend got %b want %b", {tx, busy, done}, e);
      end
      if (e[0]) tx_start = 1'b0;
      step();
    end
  endtask

  task automatic test_reset_midframe();
    logic [2:0] e;
    step();
    launch(8'hC3);
    for (int t = 0; t < 6; t++) begin
      e = exp_q.pop_front();
      vectors++;
      if ({tx, busy, done} !== e) begin
        miscompares++;
        $display("FAIL rst_mid_pre t=%0d got %b want %b", t, {tx, busy, done}, e);
      end
      step();
    end
    exp_q.delete();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({tx, busy, done} !== 3'b100) begin
      miscompares++;
      $display("FAIL rst_mid_async got %b want 100", {tx, busy, done});
    end
    tx_start = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      vectors++;
      if ({tx, busy, done} !== 3'b100) begin
        miscompares++;
        $display("FAIL rst_mid_no_done i=%0d got %b want 100", i, {tx, busy, done});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] e;
    int t;
    int d1, d2;
    d1 = -1;
    d2 = -1;
    en2 = 1'b1;
    step();
    din2   = 8'h00;
    start2 = 1'b1;
    push_frame(8'h00, C2);
    step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if ({tx2, busy2, done2} !== e) begin
        miscompares++;
        $display("FAIL b2b_first got %b want %b", {tx2, busy2, done2}, e);
      end
      if (e[0]) begin
        if (done2) d1 = cyc;
        start2 = 1'b0;
      end
      step();
    end
    din2 = 8'hFF;
    step();
    start2 = 1'b1;
    push_frame(8'hFF, C2);
    step();
    t = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if ({tx2, busy2, done2} !== e) begin
        miscompares++;
        $display("FAIL b2b_second t=%0d got %b want %b", t, {tx2, busy2, done2}, e);
      end
      if (t == 0) din2 = 8'h00;
      if (e[0]) begin
        if (done2) d2 = cyc;
        start2 = 1'b0;
      end
      t++;
      step();
    end
    vectors++;
    if (d1 < 0 || d2 < 0 || (d2 - d1) < 10*C2) begin
      miscompares++;
      $display("FAIL b2b_spacing got d1=%0d d2=%0d want both set and apart >= %0d", d1, d2, 10*C2);
    end
  endtask

  initial begin
    test_reset();
    test_single_a5();
    test_byte_07();
    test_held_start();
    test_abort();
    test_reset_midframe();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
